// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised FIFO.
// Holds default word width/depth and the pointer-width function.
package fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 16;

    // ceil(log2(n)); n is a power of two >= 4 for this FIFO
    function automatic int ptr_w(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for the FIFO: one write port, one
// registered read port, no reset. Ports: clk, we/waddr/wdata,
// re/raddr, rdata (updated only on re, otherwise holds).
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<AW)-1];

    // Nonblocking read of mem gives old data on a same-address write.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO with registered read data and flags.
// Ports: clk, rst (sync, active-high), W_en/W_data, R_en/R_data/R_valid,
// Empty, Full, Almost_empty, Almost_full, Count.
// Define FIFO_PARAM_ERR_EN to add Err_clr input and sticky
// Overflow/Underflow outputs.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = FIFO_DATA_W,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              W_en,
    input  logic [DATA_W-1:0] W_data,
    input  logic              R_en,
`ifdef FIFO_PARAM_ERR_EN
    input  logic              Err_clr,
    output logic              Overflow,
    output logic              Underflow,
`endif
    output logic [DATA_W-1:0] R_data,
    output logic              R_valid,
    output logic              Empty,
    output logic              Full,
    output logic              Almost_empty,
    output logic              Almost_full,
    output logic [AW:0]       Count
);

    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C   = (AW+1)'(AE_LEVEL);

    logic [AW:0]       w_ptr;
    logic [AW:0]       r_ptr;
    logic              wr_ok;
    logic              rd_ok;
    logic              data_ok;
    logic [DATA_W-1:0] mem_q;

    assign Count        = w_ptr - r_ptr;
    assign Empty        = (Count == '0);
    assign Full         = (Count == FULL_C);
    assign Almost_full  = (Count >= AF_C);
    assign Almost_empty = (Count <= AE_C);

    // Reset overrides any request in the same cycle.
    assign wr_ok = W_en && !Full && !rst;
    assign rd_ok = R_en && !Empty && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            R_valid <= 1'b0;
            data_ok <= 1'b0;
        end else begin
            if (wr_ok) w_ptr <= w_ptr + 1'b1;
            if (rd_ok) r_ptr <= r_ptr + 1'b1;
            R_valid <= rd_ok;
            if (rd_ok) data_ok <= 1'b1;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (w_ptr[AW-1:0]),
        .wdata (W_data),
        .re    (rd_ok),
        .raddr (r_ptr[AW-1:0]),
        .rdata (mem_q)
    );

    // Storage has no reset, so read data reads as zero until the
    // first read after reset reloads the memory output register.
    assign R_data = data_ok ? mem_q : '0;

`ifdef FIFO_PARAM_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (W_en && Full)       Overflow <= 1'b1;
            else if (Err_clr)       Overflow <= 1'b0;
            if (R_en && Empty)      Underflow <= 1'b1;
            else if (Err_clr)       Underflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param (8-bit x 16).
// Covers reset, fill/drain, full/empty collisions, wrap, mid-run reset.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       W_en;
    logic [7:0] W_data;
    logic       R_en;
    logic [7:0] R_data;
    logic       R_valid;
    logic       Empty;
    logic       Full;
    logic       Almost_empty;
    logic       Almost_full;
    logic [4:0] Count;
`ifdef FIFO_PARAM_ERR_EN
    logic       Err_clr;
    logic       Overflow;
    logic       Underflow;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_param #(
        .DATA_W   (8),
        .DEPTH    (16),
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .W_en         (W_en),
        .W_data       (W_data),
        .R_en         (R_en),
`ifdef FIFO_PARAM_ERR_EN
        .Err_clr      (Err_clr),
        .Overflow     (Overflow),
        .Underflow    (Underflow),
`endif
        .R_data       (R_data),
        .R_valid      (R_valid),
        .Empty        (Empty),
        .Full         (Full),
        .Almost_empty (Almost_empty),
        .Almost_full  (Almost_full),
        .Count        (Count)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        W_en   = 1'b0;
        W_data = '0;
        R_en   = 1'b0;
`ifdef FIFO_PARAM_ERR_EN
        Err_clr = 1'b0;
`endif
        step();
        rst = 1'b0;
        check("rst_count", Count, 0);
        check("rst_empty", Empty, 1);
        check("rst_full", Full, 0);
        check("rst_ae", Almost_empty, 1);
        check("rst_af", Almost_full, 0);
        check("rst_rvalid", R_valid, 0);
        check("rst_rdata", R_data, 0);

        // fill with 0x01..0x10
        for (int i = 0; i < 16; i++) begin
            W_en   = 1'b1;
            W_data = 8'(i + 1);
            step();
            check("fill_count", Count, i + 1);
            check("fill_af", Almost_full, (i + 1 >= 14) ? 1 : 0);
            check("fill_ae", Almost_empty, (i + 1 <= 2) ? 1 : 0);
        end
        check("fill_full", Full, 1);

        // full: pop 0x01, 0xAA rejected
        W_data = 8'hAA;
        R_en   = 1'b1;
        step();
        check("col_rdata", R_data, 8'h01);
        check("col_rvalid", R_valid, 1);
        check("col_count", Count, 15);
        check("col_full", Full, 0);
`ifdef FIFO_PARAM_ERR_EN
        check("col_ovf", Overflow, 1);
`endif

        // drain rest: 0x02..0x10, no 0xAA
        W_en = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            check("drain_rdata", R_data, i + 2);
            check("drain_rvalid", R_valid, 1);
        end
        check("drain_empty", Empty, 1);

        R_en = 1'b0;
        step();
        check("idle_rvalid", R_valid, 0);
        check("idle_hold", R_data, 8'h10);

        // read on empty rejected
        R_en = 1'b1;
        step();
        check("uf_rvalid", R_valid, 0);
        check("uf_count", Count, 0);
        check("uf_hold", R_data, 8'h10);

        // empty: write 0x55 accepted, no fall-through
        W_en   = 1'b1;
        W_data = 8'h55;
        step();
        check("ew_rvalid", R_valid, 0);
        check("ew_count", Count, 1);
        W_en = 1'b0;
        step();
        check("ew_rdata", R_data, 8'h55);
        check("ew_rvalid2", R_valid, 1);
        check("ew_empty", Empty, 1);
`ifdef FIFO_PARAM_ERR_EN
        check("ew_udf", Underflow, 1);
        R_en    = 1'b0;
        Err_clr = 1'b1;
        step();
        Err_clr = 1'b0;
        check("clr_udf", Underflow, 0);
        check("clr_ovf", Overflow, 0);
`endif

        // steady Count=5 push/pop, pointers wrap
        R_en = 1'b0;
        W_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            W_data = 8'(8'h80 + i);
            step();
        end
        check("pre_count", Count, 5);
        R_en = 1'b1;
        for (int j = 0; j < 40; j++) begin
            W_data = 8'(8'h85 + j);
            step();
            check("ss_rdata", R_data, 8'h80 + j);
            check("ss_count", Count, 5);
            check("ss_flags",
                  {Empty, Full, Almost_empty, Almost_full, R_valid},
                  5'b00001);
        end

        // grow to 9 then reset with both requests high
        R_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            W_data = 8'(8'hC0 + i);
            step();
        end
        check("pre_rst_count", Count, 9);
        rst  = 1'b1;
        R_en = 1'b1;
        step();
        rst = 1'b0;
        check("mr_count", Count, 0);
        check("mr_empty", Empty, 1);
        check("mr_rvalid", R_valid, 0);
        check("mr_rdata", R_data, 0);

        R_en   = 1'b0;
        W_data = 8'h3C;
        step();
        W_en = 1'b0;
        R_en = 1'b1;
        step();
        R_en = 1'b0;
        check("post_rdata", R_data, 8'h3C);
        check("post_count", Count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
